expr_string_gen: RTL and testbench

- Transmitter counterpart to the expression-string recognizer FSM. Given a latched list of single-digit operands and operators, emits the ASCII character stream "d(op d)*" one byte per handshake, e.g. "1+2*3".
- Output is sized to drive the recognizer's 8-bit `in` directly. Used as a stimulus source and as the producer side of the character link.

---
 rtl/expr_string_gen.sv | 156 +++++++++++++++
 tb/tb_expr_string_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_string_gen.sv
// Emits "d(op d)*" one ASCII byte per valid/ready handshake from a latched
// operand/operator list; all outputs are registered.
module expr_string_gen #(
    parameter int MAX_OPS = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [2:0]           num_ops,
    input  logic [4*MAX_OPS-1:0] digits,
    input  logic [MAX_OPS-2:0]   ops,
    output logic [7:0]           out_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGIT,
        S_OP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             n_q, n_d;
    logic [4*MAX_OPS-1:0]   digits_q, digits_d;
    logic [MAX_OPS-2:0]     ops_q, ops_d;
    logic [7:0]             char_q, char_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [MAX_OPS-1:0]     bad_digit;
    logic                   illegal;
    logic                   xfer;
    logic [2:0]             idx_inc;
    logic [3:0]             nxt_digit;
    logic                   cur_op;

    // Only operands inside the requested count are validated.
    for (genvar gi = 0; gi < MAX_OPS; gi++) begin : g_chk
        assign bad_digit[gi] = (3'(gi) < num_ops) && (digits[4*gi +: 4] > 4'd9);
    end

    assign illegal = (num_ops == 3'd0) || (num_ops > 3'(MAX_OPS)) || (|bad_digit);
    assign xfer    = valid_q && out_ready;
    assign idx_inc = idx_q + 3'd1;

    always_comb begin
        nxt_digit = 4'h0;
        cur_op    = 1'b0;
        for (int i = 0; i < MAX_OPS; i++) begin
            if (idx_inc == 3'(i)) nxt_digit = digits_q[4*i +: 4];
        end
        for (int i = 0; i < MAX_OPS - 1; i++) begin
            if (idx_q == 3'(i)) cur_op = ops_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        char_d   = char_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        n_d      = num_ops;
                        digits_d = digits;
                        ops_d    = ops;
                        idx_d    = 3'd0;
                        state_d  = S_DIGIT;
                        char_d   = 8'h30 + {4'h0, digits[3:0]};
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
            end
            S_DIGIT: begin
                if (xfer) begin
                    if (idx_q == n_q - 3'd1) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_OP;
                        char_d  = cur_op ? 8'h2A : 8'h2B;
                    end
                end
            end
            S_OP: begin
                if (xfer) begin
                    idx_d   = idx_inc;
                    state_d = S_DIGIT;
                    char_d  = 8'h30 + {4'h0, nxt_digit};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            n_q      <= 3'd0;
            digits_q <= '0;
            ops_q    <= '0;
            char_q   <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out_char  = char_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_expr_string_gen.sv
// Scoreboard bench for expr_string_gen: stimulus pushes expected strings,
// a negedge monitor pops and checks every transfer, done and err pulse.
module tb_expr_string_gen;

    localparam int MAX_OPS = 4;

    logic                 clk = 1'b0;
    logic                 clr;
    logic                 start;
    logic [2:0]           num_ops;
    logic [4*MAX_OPS-1:0] digits;
    logic [MAX_OPS-2:0]   ops;
    logic [7:0]           out_char;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    expr_string_gen #(.MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .num_ops   (num_ops),
        .digits    (digits),
        .ops       (ops),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    int          err_pending  = 0;
    int          done_seen    = 0;
    int          err_seen     = 0;
    int          xfer_cnt     = 0;
    int          rec_st       = 0;
    logic        prev_stall   = 1'b0;
    logic [7:0]  prev_char    = 8'h00;
    logic        pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_len_q.push_back(s.len());
        $display("[TB] expect \"%s\"", s);
    endtask

    // Monitor: every transfer, stall, done and err is checked here.
    always @(negedge clk) begin
        if (clr) begin
            xfer_cnt   = 0;
            rec_st     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_char", 32'(out_char), 32'(prev_char));
            end
            if (out_valid && out_ready) begin
                check("char_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("char", 32'(out_char), 32'(exp_q.pop_front()));
                $display("[TB] xfer char %02h", out_char);
                if (rec_st == 0 && out_char >= 8'h30 && out_char <= 8'h39) rec_st = 1;
                else if (rec_st == 1 && (out_char == 8'h2A || out_char == 8'h2B)) rec_st = 0;
                else rec_st = 2;
                xfer_cnt++;
            end
            if (done) begin
                check("done_expected", 32'(exp_len_q.size() != 0), 32'd1);
                if (exp_len_q.size() != 0) check("done_len", 32'(xfer_cnt), 32'(exp_len_q.pop_front()));
                check("recog_out", 32'(rec_st == 1), 32'd1);
                check("busy_at_done", 32'(busy), 32'd0);
                $display("[TB] done after %0d chars", xfer_cnt);
                xfer_cnt = 0;
                rec_st   = 0;
                done_seen++;
            end
            if (err) begin
                check("err_expected", 32'(err_pending != 0), 32'd1);
                if (err_pending != 0) err_pending--;
                err_seen++;
                $display("[TB] err pulse");
            end
            prev_stall = out_valid && !out_ready;
            prev_char  = out_char;
        end
    end

    task automatic do_start(input logic [2:0] n, input logic [15:0] dg, input logic [2:0] op);
        start   = 1'b1;
        num_ops = n;
        digits  = dg;
        ops     = op;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit use_pat);
        int d0;
        d0 = done_seen;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (done_seen != d0) return;
            if (use_pat) out_ready = pat[k % 7];
        end
        check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic illegal_start(input string name, input logic [2:0] n, input logic [15:0] dg);
        err_pending++;
        do_start(n, dg, 3'b000);
        check({name, "_err"}, 32'(err), 32'd1);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_err_clear"}, 32'(err), 32'd0);
        check({name, "_idle"}, 32'({out_valid, busy}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; start = 1'b0; num_ops = 3'd0; digits = '0; ops = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check("rst_char", 32'(out_char), 32'h00);
        check("rst_flags", 32'({out_valid, busy, done, err}), 32'd0);

        // 1: basic three-operand expression, latency and done
        push_str("1+2*3");
        do_start(3'd3, 16'h0321, 3'b010);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_char", 32'(out_char), 32'h31);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 1'b0);
        check("t1_done_one_cycle", 32'(done), 32'd0);

        // 2: single operand, upper operands are don't-care
        push_str("7");
        do_start(3'd1, 16'hFFF7, 3'b111);
        wait_done("t2", 1'b0);

        // 3: back-pressure pattern
        out_ready = pat[0];
        push_str("1+2*3");
        do_start(3'd3, 16'h0321, 3'b010);
        wait_done("t3", 1'b1);
        out_ready = 1'b1;

        // 4: illegal starts
        illegal_start("t4_n0", 3'd0, 16'h0000);
        illegal_start("t4_n5", 3'd5, 16'h1111);
        illegal_start("t4_bcd", 3'd2, 16'h00A1);

        // 5: clear mid-stream after two transfers
        push_str("1*2+3");
        do_start(3'd3, 16'h0321, 3'b001);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clr = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        out_ready = 1'b1;
        check("t5_valid_after_clr", 32'(out_valid), 32'd0);
        check("t5_busy_after_clr", 32'(busy), 32'd0);
        check("t5_abandoned_chars", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        void'(exp_len_q.pop_back());
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done", 32'(done_seen), 32'd3);
        push_str("8+5");
        do_start(3'd2, 16'h0058, 3'b000);
        wait_done("t5", 1'b0);

        // 6: start held high with inputs changed mid-stream
        push_str("6*7*8+9");
        push_str("4*5");
        start = 1'b1; num_ops = 3'd4; digits = 16'h9876; ops = 3'b011;
        repeat (3) @(posedge clk);
        #1;
        num_ops = 3'd2; digits = 16'h0054; ops = 3'b001;
        wait_done("t6a", 1'b0);
        @(posedge clk);
        #1;
        check("t6_restart_valid", 32'(out_valid), 32'd1);
        check("t6_restart_char", 32'(out_char), 32'h34);
        start = 1'b0;
        wait_done("t6b", 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("final_char_queue", 32'(exp_q.size()), 32'd0);
        check("final_done_queue", 32'(exp_len_q.size()), 32'd0);
        check("final_done_count", 32'(done_seen), 32'd6);
        check("final_err_count", 32'(err_seen), 32'd3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
